// File: rtl/cdb_arb_pkg.sv
// Shared types and widths for the common-data-bus writeback arbiter.
package cdb_arb_pkg;

    localparam int XLEN      = 32;
    localparam int PREG_W    = 6;
    localparam int ROB_TAG_W = 5;
    localparam int NUM_SRC   = 3;

    // Writeback source index; order matters for round-robin rotation.
    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_BRU = 2'd2
    } src_e;

    // One completed result travelling towards the CDB.
    typedef struct packed {
        logic [PREG_W-1:0]    tag;
        logic [XLEN-1:0]      data;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic                 rd_used;
    } wb_pkt_t;

    // Source that follows s in round-robin order (mod 3).
    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_ALU: return SRC_LSU;
            SRC_LSU: return SRC_BRU;
            SRC_BRU: return SRC_ALU;
            default: return SRC_ALU;
        endcase
    endfunction

endpackage

// File: rtl/cdb_arb_wb_fifo.sv
// Per-source in-order result FIFO. When empty, an offered packet is exposed
// directly as the head so it can be granted in the same cycle it arrives;
// in that case it is never written into storage.
module wb_fifo
    import cdb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush_i,
    input  logic    valid_i,
    output logic    ready_o,
    input  wb_pkt_t pkt_i,
    input  logic    pop_i,
    output logic    req_o,
    output wb_pkt_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    // Pointer increment with explicit wrap at DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_C) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    wb_pkt_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty_s;
    logic push_s;
    logic pop_s;
    logic store_s;
    logic take_s;

    assign empty_s = (count_q == '0);
    assign ready_o = (count_q < DEPTH_C);
    assign push_s  = valid_i && ready_o && !flush_i;
    assign pop_s   = pop_i && !flush_i;
    // A pop on an empty FIFO consumes the incoming packet directly.
    assign store_s = push_s && !(pop_s && empty_s);
    assign take_s  = pop_s && !empty_s;
    assign req_o   = !empty_s || (valid_i && !flush_i);
    assign head_o  = empty_s ? pkt_i : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (take_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (store_s && !take_s) begin
                count_d = count_q + CNT_W'(1);
            end else if (take_s && !store_s) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // Pointer/count registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_q[wr_ptr_q] <= pkt_i;
        end
    end

endmodule

// File: rtl/cdb_arb.sv
// Common-data-bus arbiter: three buffered writeback sources, round-robin
// granted one per cycle onto a registered CDB broadcast.
module cdb_arb
    import cdb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 alu_wb_valid_i,
    output logic                 alu_wb_ready_o,
    input  wb_pkt_t              alu_wb_pkt_i,
    input  logic                 lsu_wb_valid_i,
    output logic                 lsu_wb_ready_o,
    input  wb_pkt_t              lsu_wb_pkt_i,
    input  logic                 bru_wb_valid_i,
    output logic                 bru_wb_ready_o,
    input  wb_pkt_t              bru_wb_pkt_i,
    output logic                 cdb_valid_o,
    output logic [PREG_W-1:0]    cdb_tag_o,
    output logic [XLEN-1:0]      cdb_data_o,
    output logic [ROB_TAG_W-1:0] cdb_rob_tag_o,
    output logic                 cdb_rd_used_o
);

    // Request bit of a given source.
    function automatic logic src_req(input logic [NUM_SRC-1:0] r, input src_e s);
        case (s)
            SRC_ALU: return r[0];
            SRC_LSU: return r[1];
            SRC_BRU: return r[2];
            default: return 1'b0;
        endcase
    endfunction

    logic [NUM_SRC-1:0] valid_s;
    logic [NUM_SRC-1:0] ready_s;
    logic [NUM_SRC-1:0] req_s;
    logic [NUM_SRC-1:0] pop_s;
    wb_pkt_t            src_pkt_s  [NUM_SRC];
    wb_pkt_t            head_pkt_s [NUM_SRC];

    src_e    last_grant_q, last_grant_d;
    src_e    cand0_s, cand1_s, cand2_s;
    src_e    grant_src_s;
    logic    grant_any_s;
    wb_pkt_t grant_pkt_s;

    logic    cdb_valid_q, cdb_valid_d;
    wb_pkt_t cdb_pkt_q, cdb_pkt_d;

    assign valid_s       = {bru_wb_valid_i, lsu_wb_valid_i, alu_wb_valid_i};
    assign src_pkt_s[0]  = alu_wb_pkt_i;
    assign src_pkt_s[1]  = lsu_wb_pkt_i;
    assign src_pkt_s[2]  = bru_wb_pkt_i;
    assign alu_wb_ready_o = ready_s[0];
    assign lsu_wb_ready_o = ready_s[1];
    assign bru_wb_ready_o = ready_s[2];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
        wb_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush_i),
            .valid_i (valid_s[g]),
            .ready_o (ready_s[g]),
            .pkt_i   (src_pkt_s[g]),
            .pop_i   (pop_s[g]),
            .req_o   (req_s[g]),
            .head_o  (head_pkt_s[g])
        );
    end

    // Priority order starts just after the last granted source.
    assign cand0_s = next_src(last_grant_q);
    assign cand1_s = next_src(cand0_s);
    assign cand2_s = next_src(cand1_s);

    // Round-robin grant; a flush cycle grants nothing.
    always_comb begin
        grant_any_s = 1'b0;
        grant_src_s = last_grant_q;
        if (flush_i) begin
            grant_any_s = 1'b0;
        end else if (src_req(req_s, cand0_s)) begin
            grant_any_s = 1'b1;
            grant_src_s = cand0_s;
        end else if (src_req(req_s, cand1_s)) begin
            grant_any_s = 1'b1;
            grant_src_s = cand1_s;
        end else if (src_req(req_s, cand2_s)) begin
            grant_any_s = 1'b1;
            grant_src_s = cand2_s;
        end else begin
            grant_any_s = 1'b0;
        end
    end

    // Pop strobe and head mux for the granted source.
    always_comb begin
        pop_s       = '0;
        grant_pkt_s = head_pkt_s[0];
        case (grant_src_s)
            SRC_ALU: begin
                pop_s[0]    = grant_any_s;
                grant_pkt_s = head_pkt_s[0];
            end
            SRC_LSU: begin
                pop_s[1]    = grant_any_s;
                grant_pkt_s = head_pkt_s[1];
            end
            SRC_BRU: begin
                pop_s[2]    = grant_any_s;
                grant_pkt_s = head_pkt_s[2];
            end
            default: begin
                pop_s       = '0;
                grant_pkt_s = head_pkt_s[0];
            end
        endcase
    end

    // Next CDB state: payload holds when nothing is granted.
    always_comb begin
        cdb_valid_d  = grant_any_s;
        cdb_pkt_d    = cdb_pkt_q;
        last_grant_d = last_grant_q;
        if (grant_any_s) begin
            cdb_pkt_d    = grant_pkt_s;
            last_grant_d = grant_src_s;
        end else begin
            cdb_pkt_d    = cdb_pkt_q;
            last_grant_d = last_grant_q;
        end
    end

    // CDB output and arbitration-pointer registers; BRU as last grant
    // makes the ALU first in line after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_q  <= 1'b0;
            cdb_pkt_q    <= '0;
            last_grant_q <= SRC_BRU;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_pkt_q    <= cdb_pkt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign cdb_valid_o   = cdb_valid_q;
    assign cdb_tag_o     = cdb_pkt_q.tag;
    assign cdb_data_o    = cdb_pkt_q.data;
    assign cdb_rob_tag_o = cdb_pkt_q.rob_tag;
    assign cdb_rd_used_o = cdb_pkt_q.rd_used;

endmodule

// File: tb/tb_cdb_arb.sv
// Self-checking bench for cdb_arb against a queue-based reference model.
module tb_cdb_arb;
    import cdb_arb_pkg::*;

    localparam int DEPTH = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush_i;
    logic                 alu_wb_valid_i, lsu_wb_valid_i, bru_wb_valid_i;
    logic                 alu_wb_ready_o, lsu_wb_ready_o, bru_wb_ready_o;
    wb_pkt_t              alu_wb_pkt_i, lsu_wb_pkt_i, bru_wb_pkt_i;
    logic                 cdb_valid_o;
    logic [PREG_W-1:0]    cdb_tag_o;
    logic [XLEN-1:0]      cdb_data_o;
    logic [ROB_TAG_W-1:0] cdb_rob_tag_o;
    logic                 cdb_rd_used_o;

    cdb_arb #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .alu_wb_valid_i (alu_wb_valid_i),
        .alu_wb_ready_o (alu_wb_ready_o),
        .alu_wb_pkt_i   (alu_wb_pkt_i),
        .lsu_wb_valid_i (lsu_wb_valid_i),
        .lsu_wb_ready_o (lsu_wb_ready_o),
        .lsu_wb_pkt_i   (lsu_wb_pkt_i),
        .bru_wb_valid_i (bru_wb_valid_i),
        .bru_wb_ready_o (bru_wb_ready_o),
        .bru_wb_pkt_i   (bru_wb_pkt_i),
        .cdb_valid_o    (cdb_valid_o),
        .cdb_tag_o      (cdb_tag_o),
        .cdb_data_o     (cdb_data_o),
        .cdb_rob_tag_o  (cdb_rob_tag_o),
        .cdb_rd_used_o  (cdb_rd_used_o)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per source, last grant as plain integer.
    wb_pkt_t q_alu[$];
    wb_pkt_t q_lsu[$];
    wb_pkt_t q_bru[$];
    int      m_last;
    logic    m_valid;
    wb_pkt_t m_pkt;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int qsize(input int s);
        if (s == 0) return q_alu.size();
        else if (s == 1) return q_lsu.size();
        else return q_bru.size();
    endfunction

    function automatic void qpush(input int s, input wb_pkt_t p);
        if (s == 0) q_alu.push_back(p);
        else if (s == 1) q_lsu.push_back(p);
        else q_bru.push_back(p);
    endfunction

    function automatic wb_pkt_t qpop(input int s);
        if (s == 0) return q_alu.pop_front();
        else if (s == 1) return q_lsu.pop_front();
        else return q_bru.pop_front();
    endfunction

    function automatic wb_pkt_t rand_pkt();
        wb_pkt_t p;
        p.tag     = PREG_W'($urandom);
        p.data    = $urandom;
        p.rob_tag = ROB_TAG_W'($urandom);
        p.rd_used = 1'($urandom);
        return p;
    endfunction

    function automatic wb_pkt_t mk_pkt(input int tag, input int data, input int rob, input bit used);
        wb_pkt_t p;
        p.tag     = PREG_W'(tag);
        p.data    = XLEN'(data);
        p.rob_tag = ROB_TAG_W'(rob);
        p.rd_used = used;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q_alu.delete();
        q_lsu.delete();
        q_bru.delete();
        m_last  = 2;
        m_valid = 1'b0;
        m_pkt   = '0;
    endfunction

    // One cycle of the model: accept pushes, then pick round-robin from last+1.
    function automatic void model_cycle(input logic [2:0] v, input wb_pkt_t p0, input wb_pkt_t p1,
                                        input wb_pkt_t p2, input logic fl);
        bit acc [3];
        int g;
        wb_pkt_t pk [3];
        pk[0] = p0; pk[1] = p1; pk[2] = p2;
        if (fl) begin
            q_alu.delete();
            q_lsu.delete();
            q_bru.delete();
            m_valid = 1'b0;
        end else begin
            for (int s = 0; s < 3; s++) acc[s] = v[s] && (qsize(s) < DEPTH);
            for (int s = 0; s < 3; s++) if (acc[s]) qpush(s, pk[s]);
            g = -1;
            for (int i = 0; i < 3; i++) begin
                int s;
                s = (m_last + 1 + i) % 3;
                if (g < 0 && qsize(s) > 0) g = s;
            end
            if (g >= 0) begin
                m_pkt   = qpop(g);
                m_valid = 1'b1;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
    endfunction

    task automatic check_cdb(input string tag);
        chk({tag, "_valid"}, 64'(cdb_valid_o), 64'(m_valid));
        chk({tag, "_pkt"}, 64'({cdb_tag_o, cdb_data_o, cdb_rob_tag_o, cdb_rd_used_o}), 64'(m_pkt));
    endtask

    task automatic check_ready(input string tag);
        chk({tag, "_alu_rdy"}, 64'(alu_wb_ready_o), 64'(qsize(0) < DEPTH));
        chk({tag, "_lsu_rdy"}, 64'(lsu_wb_ready_o), 64'(qsize(1) < DEPTH));
        chk({tag, "_bru_rdy"}, 64'(bru_wb_ready_o), 64'(qsize(2) < DEPTH));
    endtask

    // Drive one cycle at the falling edge, check, advance to next falling edge.
    task automatic step(input string tag, input logic [2:0] v, input wb_pkt_t p0, input wb_pkt_t p1,
                        input wb_pkt_t p2, input logic fl);
        alu_wb_valid_i = v[0]; alu_wb_pkt_i = p0;
        lsu_wb_valid_i = v[1]; lsu_wb_pkt_i = p1;
        bru_wb_valid_i = v[2]; bru_wb_pkt_i = p2;
        flush_i        = fl;
        #1;
        check_ready(tag);
        model_cycle(v, p0, p1, p2, fl);
        @(posedge clk);
        @(negedge clk);
        check_cdb(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 3'b000, rand_pkt(), rand_pkt(), rand_pkt(), 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        flush_i = 1'b0;
        alu_wb_valid_i = 1'b0; lsu_wb_valid_i = 1'b0; bru_wb_valid_i = 1'b0;
        model_reset();
        #1;
        check_cdb(tag);
        check_ready(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        alu_wb_pkt_i = '0; lsu_wb_pkt_i = '0; bru_wb_pkt_i = '0;
        do_reset("reset");

        // Single ALU result: visible next cycle, gone the cycle after, payload held.
        step("s36a", 3'b001, mk_pkt(5, 32'hDEAD, 3, 1'b1), rand_pkt(), rand_pkt(), 1'b0);
        chk("s36_valid", 64'(cdb_valid_o), 64'd1);
        chk("s36_tag", 64'(cdb_tag_o), 64'd5);
        chk("s36_data", 64'(cdb_data_o), 64'hDEAD);
        chk("s36_rob", 64'(cdb_rob_tag_o), 64'd3);
        idle("s36b", 1);
        chk("s36_drop", 64'(cdb_valid_o), 64'd0);

        // All three in one cycle after reset: ALU, LSU, BRU order.
        do_reset("reset2");
        step("s37", 3'b111, mk_pkt(1, 32'h111, 1, 1'b1), mk_pkt(2, 32'h222, 2, 1'b0),
             mk_pkt(3, 32'h333, 3, 1'b1), 1'b0);
        chk("s37_first", 64'(cdb_tag_o), 64'd1);
        idle("s37b", 1);
        chk("s37_second", 64'(cdb_tag_o), 64'd2);
        idle("s37c", 1);
        chk("s37_third", 64'(cdb_tag_o), 64'd3);
        chk("s37_rdused0", 64'(cdb_rd_used_o), 64'd1);
        idle("s37d", 1);

        // LSU holds one entry while ALU pushes every cycle.
        step("s38a", 3'b011, rand_pkt(), mk_pkt(9, 32'h9, 9, 1'b0), rand_pkt(), 1'b0);
        for (int i = 0; i < 4; i++) step("s38b", 3'b001, rand_pkt(), rand_pkt(), rand_pkt(), 1'b0);
        idle("s38c", 2);

        // BRU back-to-back with ALU also pushing: backpressure.
        for (int i = 0; i < 6; i++) step("s39", 3'b101, rand_pkt(), rand_pkt(), rand_pkt(), 1'b0);
        idle("s39b", 6);

        // Flush with FIFOs holding 2/1/0 entries and a push offered.
        do_reset("reset3");
        step("s40a", 3'b111, rand_pkt(), rand_pkt(), rand_pkt(), 1'b0);
        step("s40b", 3'b011, rand_pkt(), rand_pkt(), rand_pkt(), 1'b0);
        step("s40c", 3'b001, rand_pkt(), rand_pkt(), rand_pkt(), 1'b0);
        step("s40f", 3'b101, rand_pkt(), rand_pkt(), rand_pkt(), 1'b1);
        chk("s40_novalid", 64'(cdb_valid_o), 64'd0);
        chk("s40_rdy", 64'({alu_wb_ready_o, lsu_wb_ready_o, bru_wb_ready_o}), 64'd7);
        idle("s40d", 3);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] v;
            logic       fl;
            v  = 3'($urandom);
            fl = ($urandom_range(0, 31) == 0);
            step("rand", v, rand_pkt(), rand_pkt(), rand_pkt(), fl);
        end

        // Reset between edges with entries buffered.
        step("s41a", 3'b111, rand_pkt(), rand_pkt(), rand_pkt(), 1'b0);
        chk("s41_pre", 64'(cdb_valid_o), 64'd1);
        alu_wb_valid_i = 1'b0; lsu_wb_valid_i = 1'b0; bru_wb_valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("s41_valid", 64'(cdb_valid_o), 64'd0);
        check_cdb("s41_async");
        check_ready("s41_async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle("s41b", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
